operand_split: RTL
==================

OPERAND_SPLIT -- requirements
Module: operand_split

Interface
REQ-001 Parameter: WIDTH, default 32, data word width in bits; all data ports below are WIDTH wide.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream word valid.
REQ-005 Port: in_ready  output  1  block can accept in_word this cycle.
REQ-006 Port: in_word  input  WIDTH  packed operand stream word.
REQ-007 Port: fast  input  1  sampled with a first-of-pair word; broadcast that word to both operands.
REQ-008 Port: out_valid  output  1  opa/opb pair valid.
REQ-009 Port: out_ready  input  1  downstream accepts the pair.
REQ-010 Port: opa  output  WIDTH  first operand, registered.
REQ-011 Port: opb  output  WIDTH  second operand, registered.
REQ-012 Port: sign_diff  output  1  registered opa[WIDTH-1] XOR opb[WIDTH-1].
REQ-013 Port: special  output  1  registered opa[WIDTH-2] OR opb[WIDTH-2].
REQ-014 Port: pair_cnt  output  16  count of retired pairs.
REQ-015 in_word SHALL be annotated taint_source; opa, opb SHALL be annotated taint_sink.

Function
REQ-016 The block SHALL implement an FSM with states IDLE (nothing held), HAVE_A (opa captured), FULL (pair held, out_valid=1).
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1 in the same cycle; an output transfer when out_valid and out_ready are both 1.
REQ-018 in_ready SHALL be combinational: 1 in IDLE and HAVE_A; in FULL, equal to out_ready.
REQ-019 IDLE + input transfer, fast=0: opa <= in_word, next HAVE_A.
REQ-020 IDLE + input transfer, fast=1: opa <= in_word, opb <= in_word, next FULL.
REQ-021 HAVE_A + input transfer: opb <= in_word, next FULL; fast SHALL be ignored.
REQ-022 FULL + output transfer, no input transfer: next IDLE.
REQ-023 FULL + output transfer + input transfer in the same cycle: the pair SHALL retire, and the new word SHALL be handled as in IDLE (REQ-019/020), with no bubble.
REQ-024 While out_valid=1 and out_ready=0, opa, opb, sign_diff and special SHALL hold stable.
REQ-025 sign_diff and special SHALL be registered in the same cycle that the pair becomes FULL, consistent with the captured opa/opb.
REQ-026 Latency: out_valid SHALL rise on the cycle after the input transfer that completes a pair.
REQ-027 pair_cnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-028 in_valid with in_ready=0 SHALL have no effect; the word is not consumed.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 On rst_n=0, the state SHALL go to IDLE immediately and asynchronously.
REQ-031 On rst_n=0, opa, opb, sign_diff, special, out_valid and pair_cnt SHALL all be 0.
REQ-032 A half-captured opa in HAVE_A SHALL be discarded by reset; the first word after reset is always a first-of-pair word.
REQ-033 The block SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 Package operand_split_pkg SHALL hold the WIDTH default, the state encodings (IDLE=2'b00, HAVE_A=2'b01, FULL=2'b10) and the pair_cnt width constant (16).
REQ-035 The design SHALL be a single module with no sub-modules; the FSM, data registers and counter are in operand_split.

Verification
REQ-036 Scenario: reset, then words 0x8000_0001 and 0x4000_0002 with fast=0 and out_ready=1 -> out_valid=1 one cycle after the 2nd transfer; opa=0x8000_0001, opb=0x4000_0002, sign_diff=1, special=1; pair_cnt=1 after retire.
REQ-037 Scenario: IDLE, word 0x1234_5678 with fast=1 -> next cycle opa=opb=0x1234_5678, sign_diff=0, special=0.
REQ-038 Scenario: FULL with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout and outputs stable; out_ready=1 for 1 cycle -> pair retires and the new word is captured into opa in that same cycle.
REQ-039 Scenario: HAVE_A holding 0xDEAD_BEEF, pulse rst_n low mid-cycle -> state IDLE and all outputs 0 immediately; next two words form a fresh pair.
REQ-040 Scenario: back-to-back streaming of 65537 pairs with out_ready=1 -> pair_cnt wraps to 0x0001 and throughput is 1 pair per 2 cycles with no lost words.

Source files
------------

// File: rtl/operand_split_pkg.sv
// operand_split_pkg
// Shared constants and types for the operand splitter.
//   DEFAULT_WIDTH : default data word width in bits
//   CNT_WIDTH     : width of the retired-pair counter
//   state_t       : FSM state encoding (IDLE / HAVE_A / FULL)
package operand_split_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    FULL   = 2'b10
  } state_t;

endpackage

// File: rtl/operand_split.sv
// operand_split
// Collects a packed operand stream into registered (opa, opb) pairs.
// The first word of a pair goes to opa. The second word goes to opb.
// If fast is set with a first word, that word is copied to both
// operands and the pair completes at once.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream word valid
//   in_ready   : block can take in_word this cycle (combinational)
//   in_word    : operand stream word
//   fast       : broadcast this first-of-pair word to both operands
//   out_valid  : opa/opb pair valid
//   out_ready  : downstream accepts the pair
//   opa, opb   : registered operands
//   sign_diff  : registered opa[MSB] ^ opb[MSB]
//   special    : registered opa[MSB-1] | opb[MSB-1]
//   pair_cnt   : count of retired pairs, wraps
module operand_split
  import operand_split_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  (* taint_source = "true" *) input  logic [WIDTH-1:0] in_word,
  input  logic                                      fast,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  (* taint_sink = "true" *)   output logic [WIDTH-1:0] opa,
  (* taint_sink = "true" *)   output logic [WIDTH-1:0] opb,
  output logic                                      sign_diff,
  output logic                                      special,
  output logic [CNT_WIDTH-1:0]                      pair_cnt
);

  state_t state;

  logic in_xfer;
  logic out_xfer;
  logic first_word;
  logic second_word;

  // A held pair blocks input unless it retires in the same cycle.
  // Because of this, an input transfer in FULL always comes with an
  // output transfer. That is what makes zero-bubble streaming possible.
  always_comb begin
    in_ready    = (state != FULL) || out_ready;
    in_xfer     = in_valid && in_ready;
    out_xfer    = out_valid && out_ready;
    // A word is first-of-pair unless an opa is already waiting.
    // A word taken in FULL is first-of-pair because the old pair retires.
    // An unknown state also treats the word as first-of-pair.
    first_word  = in_xfer && (state != HAVE_A);
    second_word = in_xfer && (state == HAVE_A);
  end

  // Single-block FSM with registered operands, flags and counter.
  // The flags are computed from the incoming word and not from opb.
  // This keeps them consistent with the pair that appears next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      sign_diff <= 1'b0;
      special   <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      if (out_xfer) begin
        pair_cnt <= pair_cnt + CNT_WIDTH'(1);
      end

      if (first_word) begin
        opa <= in_word;
        if (fast) begin
          opb       <= in_word;
          sign_diff <= 1'b0;
          special   <= in_word[WIDTH-2];
          state     <= FULL;
          out_valid <= 1'b1;
        end else begin
          state     <= HAVE_A;
          out_valid <= 1'b0;
        end
      end else if (second_word) begin
        opb       <= in_word;
        sign_diff <= opa[WIDTH-1] ^ in_word[WIDTH-1];
        special   <= opa[WIDTH-2] | in_word[WIDTH-2];
        state     <= FULL;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else if (state != IDLE && state != HAVE_A && state != FULL) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
